// File: rtl/vga_pkg.sv
// Shared definitions for the snake game VGA colour path.
// Contents: board cell-state encoding, cell size shift, default colour
// constants (12-bit {R,G,B} 4:4:4).
package vga_pkg;

  localparam int unsigned CELL_SHIFT = 4;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_HEAD  = 3'd1,
    ST_BODY  = 3'd2,
    ST_FOOD  = 3'd3,
    ST_WALL  = 3'd4,
    ST_DEAD  = 3'd5,
    ST_RSVD6 = 3'd6,
    ST_RSVD7 = 3'd7
  } cell_state_e;

  localparam logic [11:0] C_BG   = 12'h000;
  localparam logic [11:0] C_GRID = 12'h333;
  localparam logic [11:0] C_HEAD = 12'h0F0;
  localparam logic [11:0] C_EYE  = 12'h000;
  localparam logic [11:0] C_BODY = 12'h0A0;
  localparam logic [11:0] C_EDGE = 12'h050;
  localparam logic [11:0] C_FOOD = 12'hF00;
  localparam logic [11:0] C_WALL = 12'h888;
  localparam logic [11:0] C_MORT = 12'h444;
  localparam logic [11:0] C_DEAD = 12'hF80;
  localparam logic [11:0] C_RSVD = 12'hF0F;

  // |2*v-15| for a 4-bit in-cell offset, always odd in 1..15.
  function automatic logic [5:0] centre_dist(input logic [3:0] v);
    logic [5:0] twice;
    twice = {1'b0, v, 1'b0};
    centre_dist = v[3] ? (twice - 6'd15) : (6'd15 - twice);
  endfunction

endpackage

// File: rtl/vga_cell_pattern.sv
// Combinational procedural pattern for one 16x16 board cell.
// Ports: state (cell state), ox/oy (pixel offset inside the cell),
//        rgb (12-bit colour for that pixel).
// Optional feature: GRID_LINES_EN draws grid lines on empty cells.
module vga_cell_pattern
  import vga_pkg::*;
#(
  parameter logic [11:0] P_BG   = C_BG,
  parameter logic [11:0] P_GRID = C_GRID,
  parameter logic [11:0] P_HEAD = C_HEAD,
  parameter logic [11:0] P_EYE  = C_EYE,
  parameter logic [11:0] P_BODY = C_BODY,
  parameter logic [11:0] P_EDGE = C_EDGE,
  parameter logic [11:0] P_FOOD = C_FOOD,
  parameter logic [11:0] P_WALL = C_WALL,
  parameter logic [11:0] P_MORT = C_MORT,
  parameter logic [11:0] P_DEAD = C_DEAD,
  parameter logic [11:0] P_RSVD = C_RSVD
) (
  input  logic [2:0]  state,
  input  logic [3:0]  ox,
  input  logic [3:0]  oy,
  output logic [11:0] rgb
);

  logic        eye_row;
  logic        eye_col;
  logic        on_edge;
  logic [5:0]  diamond_sum;
  logic        in_diamond;
  logic [2:0]  mortar_col;
  logic        is_mortar;

  always_comb begin
    eye_row     = (oy == 4'd4) || (oy == 4'd5);
    eye_col     = (ox == 4'd4) || (ox == 4'd5) || (ox == 4'd10) || (ox == 4'd11);
    on_edge     = (ox == 4'd0) || (ox == 4'd15) || (oy == 4'd0) || (oy == 4'd15);
    diamond_sum = centre_dist(ox) + centre_dist(oy);
    in_diamond  = (diamond_sum <= 6'd16);
    // Lower half-cell row of bricks is offset by half a brick.
    mortar_col  = oy[3] ? 3'd4 : 3'd0;
    is_mortar   = (oy[2:0] == 3'd0) || (ox[2:0] == mortar_col);
  end

  always_comb begin
    rgb = P_RSVD;
    case (cell_state_e'(state))
      ST_EMPTY: begin
`ifdef GRID_LINES_EN
        rgb = ((ox == 4'd0) || (oy == 4'd0)) ? P_GRID : P_BG;
`else
        rgb = P_BG;
`endif
      end
      ST_HEAD:  rgb = (eye_row && eye_col) ? P_EYE : P_HEAD;
      ST_BODY:  rgb = on_edge ? P_EDGE : P_BODY;
      ST_FOOD:  rgb = in_diamond ? P_FOOD : P_BG;
      ST_WALL:  rgb = is_mortar ? P_MORT : P_WALL;
      ST_DEAD:  rgb = P_DEAD;
      default:  rgb = P_RSVD;
    endcase
  end

endmodule

// File: rtl/vga_control.sv
// Per-pixel colour generator for the snake game's VGA path.
// Ports: clk (pixel clock), rst (sync, active-high), valid (active video),
//        x_ptr/y_ptr (beam position), blockState (state of cell under beam),
//        RGB (registered 12-bit colour, 1-cycle latency).
// Optional feature: GRID_LINES_EN (grid lines on empty cells).
module vga_control
  import vga_pkg::*;
#(
  parameter logic [11:0] C_BG_P   = C_BG,
  parameter logic [11:0] C_GRID_P = C_GRID,
  parameter logic [11:0] C_HEAD_P = C_HEAD,
  parameter logic [11:0] C_EYE_P  = C_EYE,
  parameter logic [11:0] C_BODY_P = C_BODY,
  parameter logic [11:0] C_EDGE_P = C_EDGE,
  parameter logic [11:0] C_FOOD_P = C_FOOD,
  parameter logic [11:0] C_WALL_P = C_WALL,
  parameter logic [11:0] C_MORT_P = C_MORT,
  parameter logic [11:0] C_DEAD_P = C_DEAD,
  parameter logic [11:0] C_RSVD_P = C_RSVD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [9:0]  x_ptr,
  input  logic [9:0]  y_ptr,
  input  logic [2:0]  blockState,
  output logic [11:0] RGB
);

  logic [11:0] cell_rgb;
  logic [11:0] rgb_d;
  logic [11:0] rgb_q;

  vga_cell_pattern #(
    .P_BG   (C_BG_P),
    .P_GRID (C_GRID_P),
    .P_HEAD (C_HEAD_P),
    .P_EYE  (C_EYE_P),
    .P_BODY (C_BODY_P),
    .P_EDGE (C_EDGE_P),
    .P_FOOD (C_FOOD_P),
    .P_WALL (C_WALL_P),
    .P_MORT (C_MORT_P),
    .P_DEAD (C_DEAD_P),
    .P_RSVD (C_RSVD_P)
  ) u_pattern (
    .state (blockState),
    .ox    (x_ptr[CELL_SHIFT-1:0]),
    .oy    (y_ptr[CELL_SHIFT-1:0]),
    .rgb   (cell_rgb)
  );

  always_comb begin
    rgb_d = '0;
    if (valid) rgb_d = cell_rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= rgb_d;
  end

  assign RGB = rgb_q;

endmodule

// File: tb/tb_vga_control.sv
// Self-checking bench for vga_control: a behavioural model compared every
// cycle, plus a directed table of hand-computed literal expectations.
module tb_vga_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [9:0]  x_ptr;
  logic [9:0]  y_ptr;
  logic [2:0]  blockState;
  logic [11:0] RGB;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vga_control dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .x_ptr      (x_ptr),
    .y_ptr      (y_ptr),
    .blockState (blockState),
    .RGB        (RGB)
  );

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: RGB=%03h expected %03h at %0t", name, act, exp, $time);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Pixel colour straight from the geometric description of each cell.
  function automatic logic [11:0] model(input bit r, input bit v, input int st,
                                        input int x, input int y);
    int ox, oy;
    ox = x % 16;
    oy = y % 16;
    if (r || !v) return 12'h000;
    case (st)
      0: begin
`ifdef GRID_LINES_EN
        if (ox == 0 || oy == 0) return 12'h333;
`endif
        return 12'h000;
      end
      1: return ((oy >= 4 && oy <= 5) &&
                 ((ox >= 4 && ox <= 5) || (ox >= 10 && ox <= 11))) ? 12'h000 : 12'h0F0;
      2: return (ox == 0 || ox == 15 || oy == 0 || oy == 15) ? 12'h050 : 12'h0A0;
      3: return (iabs(2*ox - 15) + iabs(2*oy - 15) <= 16) ? 12'hF00 : 12'h000;
      4: return ((oy % 8 == 0) || (ox % 8 == ((oy >= 8) ? 4 : 0))) ? 12'h444 : 12'h888;
      5: return 12'hF80;
      default: return 12'hF0F;
    endcase
  endfunction

  logic [11:0] exp_rgb;
  bit          have_exp = 0;

  always @(posedge clk) begin
    exp_rgb  <= model(rst, valid, blockState, x_ptr, y_ptr);
    have_exp <= 1'b1;
  end

  always @(negedge clk) begin
    if (have_exp) check("model", RGB, exp_rgb);
  end

  typedef struct {
    bit          r;
    bit          v;
    int          st;
    int          x;
    int          y;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit v, input int st, input int x,
                     input int y, input logic [11:0] exp, input string name);
    vec_t t;
    t.r = r; t.v = v; t.st = st; t.x = x; t.y = y; t.exp = exp; t.name = name;
    vecs.push_back(t);
  endtask

  task automatic drive(input bit r, input bit v, input int st, input int x, input int y);
    rst        = r;
    valid      = v;
    blockState = st[2:0];
    x_ptr      = x[9:0];
    y_ptr      = y[9:0];
  endtask

  initial begin
    logic [11:0] grid_exp;
`ifdef GRID_LINES_EN
    grid_exp = 12'h333;
`else
    grid_exp = 12'h000;
`endif
    add(1, 1, 2,  20,  20, 12'h000, "reset_a");
    add(1, 1, 2,  20,  20, 12'h000, "reset_b");
    add(0, 0, 1, 300, 200, 12'h000, "blank");
    add(0, 1, 0, 300, 200, 12'h000, "empty");
    add(0, 1, 0, 304, 200, grid_exp, "empty_ox0");
    add(0, 1, 2,  16,  20, 12'h050, "body_edge");
    add(0, 1, 2,  20,  20, 12'h0A0, "body_fill");
    add(0, 1, 2,  20,  31, 12'h050, "body_oy15");
    add(0, 1, 1,   4,   4, 12'h000, "head_eye");
    add(0, 1, 1,   8,   8, 12'h0F0, "head_fill");
    add(0, 1, 1,  10,   5, 12'h000, "head_eye_r");
    add(0, 1, 3,   7,   7, 12'hF00, "food_ctr");
    add(0, 1, 3,   7,   0, 12'hF00, "food_sum16");
    add(0, 1, 3,   0,   0, 12'h000, "food_corner");
    add(0, 1, 4,   1,   1, 12'h888, "wall_brick");
    add(0, 1, 5,   1,   1, 12'hF80, "dead");
    add(0, 1, 7,   1,   1, 12'hF0F, "rsvd7");
    add(0, 1, 4,   4,   9, 12'h444, "wall_offset");
    add(0, 1, 5,   0,   0, 12'hF80, "dead_b");
    add(0, 1, 4,   0,   9, 12'h888, "wall_lower");
    add(0, 1, 6,   3,   3, 12'hF0F, "rsvd6");
    add(1, 1, 2,  20,  20, 12'h000, "reset_mid");
    add(0, 1, 2,  20,  20, 12'h0A0, "after_reset");

    drive(1, 1, 2, 20, 20);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) check(vecs[i-1].name, RGB, vecs[i-1].exp);
      drive(vecs[i].r, vecs[i].v, vecs[i].st, vecs[i].x, vecs[i].y);
    end
    @(negedge clk);
    check(vecs[vecs.size()-1].name, RGB, vecs[vecs.size()-1].exp);

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 1023));
      @(negedge clk);
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
